// File: rtl/uart.sv
// uart: full-duplex async serial transceiver with configurable frame format and RX error flags.
// Optional RTS/CTS hardware flow control is enabled by defining UART_FLOW_CTRL_EN.
module uart #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_WIDTH = 1,
   parameter int PARITY     = 0,
   parameter int BAUD_DIV   = 868
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_parity_err,
   output logic                  rx_frame_err,
   output logic                  rx_overrun,
   output logic                  txd,
   input  logic                  rxd,
   output logic                  rts,
   input  logic                  cts
);

   localparam int            BW        = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   // Start-bit recheck lands so the registered result appears exactly half a bit in.
   localparam logic [BW-1:0] BAUD_MID  = BW'(BAUD_DIV / 2 - 2);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_WIDTH - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_WIDTH - 1);
   localparam logic          PAR_ODD   = (PARITY == 1);

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
      if (PAR_ODD) begin
         return ~(^d);
      end else begin
         return ^d;
      end
   endfunction

   tx_state_e             tx_state_q, tx_state_d;
   logic [BW-1:0]         tx_baud_q, tx_baud_d;
   logic [3:0]            tx_bit_q, tx_bit_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic                  tx_par_q, tx_par_d;
   logic                  txd_q, txd_d;
   logic                  tx_ready_s;
   logic                  tx_bit_end_s;

   rx_state_e             rx_state_q, rx_state_d;
   logic [1:0]            rx_sync_q, rx_sync_d;
   logic                  rx_prev_q, rx_prev_d;
   logic [BW-1:0]         rx_baud_q, rx_baud_d;
   logic [3:0]            rx_bit_q, rx_bit_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic                  rx_perr_q, rx_perr_d;
   logic                  rx_ferr_q, rx_ferr_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rx_perr_out_q, rx_perr_out_d;
   logic                  rx_ferr_out_q, rx_ferr_out_d;
   logic                  rx_overrun_q, rx_overrun_d;
   logic                  rx_s;
   logic                  rx_bit_end_s;
   logic                  rx_done_s;

`ifdef UART_FLOW_CTRL_EN
   logic [1:0] cts_sync_q, cts_sync_d;

   always_comb begin
      cts_sync_d = {cts_sync_q[0], cts};
   end

   // Reset to "peer ready" so tx_ready comes out of reset high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cts_sync_q <= 2'b11;
      end else begin
         cts_sync_q <= cts_sync_d;
      end
   end

   assign tx_ready_s = (tx_state_q == TX_IDLE) && cts_sync_q[1];
   assign rts        = ~rx_valid_q;
`else
   logic unused_cts_s;
   assign unused_cts_s = cts;
   assign tx_ready_s   = (tx_state_q == TX_IDLE);
   assign rts          = 1'b1;
`endif

   assign tx_bit_end_s = (tx_baud_q == BAUD_LAST);

   // TX sequencing: txd is registered alongside the state so each bit is glitch-free.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q + 1'b1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      txd_d      = txd_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_baud_d = '0;
            tx_bit_d  = 4'd0;
            if (tx_valid && tx_ready_s) begin
               tx_state_d = TX_START;
               tx_shift_d = tx_data;
               tx_par_d   = parity_bit(tx_data);
               txd_d      = 1'b0;
            end else begin
               txd_d = 1'b1;
            end
         end
         TX_START: begin
            if (tx_bit_end_s) begin
               tx_state_d = TX_DATA;
               tx_baud_d  = '0;
               tx_bit_d   = 4'd0;
               txd_d      = tx_shift_q[0];
            end else begin
               txd_d = 1'b0;
            end
         end
         TX_DATA: begin
            if (tx_bit_end_s) begin
               tx_baud_d = '0;
               if (tx_bit_q == DATA_LAST) begin
                  tx_bit_d = 4'd0;
                  if (PARITY != 0) begin
                     tx_state_d = TX_PARITY;
                     txd_d      = tx_par_q;
                  end else begin
                     tx_state_d = TX_STOP;
                     txd_d      = 1'b1;
                  end
               end else begin
                  tx_bit_d   = tx_bit_q + 4'd1;
                  tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
                  txd_d      = tx_shift_q[1];
               end
            end else begin
               txd_d = txd_q;
            end
         end
         TX_PARITY: begin
            if (tx_bit_end_s) begin
               tx_state_d = TX_STOP;
               tx_baud_d  = '0;
               tx_bit_d   = 4'd0;
               txd_d      = 1'b1;
            end else begin
               txd_d = tx_par_q;
            end
         end
         TX_STOP: begin
            txd_d = 1'b1;
            if (tx_bit_end_s) begin
               tx_baud_d = '0;
               if (tx_bit_q == STOP_LAST) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
               end
            end else begin
               tx_bit_d = tx_bit_q;
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_baud_d  = '0;
            txd_d      = 1'b1;
         end
      endcase
   end

   assign rx_s         = rx_sync_q[1];
   assign rx_bit_end_s = (rx_baud_q == BAUD_LAST);

   // RX sampling and the one-word output register with overrun detection.
   always_comb begin
      rx_sync_d     = {rx_sync_q[0], rxd};
      rx_prev_d     = rx_s;
      rx_state_d    = rx_state_q;
      rx_baud_d     = rx_baud_q + 1'b1;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_perr_d     = rx_perr_q;
      rx_ferr_d     = rx_ferr_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      rx_perr_out_d = rx_perr_out_q;
      rx_ferr_out_d = rx_ferr_out_q;
      rx_overrun_d  = 1'b0;
      rx_done_s     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_baud_d = '0;
            rx_bit_d  = 4'd0;
            rx_perr_d = 1'b0;
            rx_ferr_d = 1'b0;
            if (rx_prev_q && !rx_s) begin
               rx_state_d = RX_START;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_baud_q == BAUD_MID) begin
               rx_baud_d = '0;
               if (rx_s) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
               end
            end else begin
               rx_state_d = RX_START;
            end
         end
         RX_DATA: begin
            if (rx_bit_end_s) begin
               rx_baud_d  = '0;
               rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
               if (rx_bit_q == DATA_LAST) begin
                  rx_bit_d   = 4'd0;
                  rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 4'd1;
               end
            end else begin
               rx_shift_d = rx_shift_q;
            end
         end
         RX_PARITY: begin
            if (rx_bit_end_s) begin
               rx_baud_d  = '0;
               rx_perr_d  = (^rx_shift_q) ^ rx_s ^ PAR_ODD;
               rx_state_d = RX_STOP;
            end else begin
               rx_perr_d = rx_perr_q;
            end
         end
         RX_STOP: begin
            if (rx_bit_end_s) begin
               rx_baud_d = '0;
               rx_ferr_d = rx_ferr_q | ~rx_s;
               if (rx_bit_q == STOP_LAST) begin
                  rx_done_s  = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_bit_d = rx_bit_q + 4'd1;
               end
            end else begin
               rx_ferr_d = rx_ferr_q;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
            rx_baud_d  = '0;
         end
      endcase

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end

      if (rx_done_s) begin
         if (rx_valid_q && !rx_ready) begin
            rx_overrun_d = 1'b1;
         end else begin
            rx_data_d     = rx_shift_q;
            rx_perr_out_d = rx_perr_q;
            rx_ferr_out_d = rx_ferr_q | ~rx_s;
            rx_valid_d    = 1'b1;
         end
      end else begin
         rx_overrun_d = 1'b0;
      end
   end

   // State registers; line idles at MARK and synchronisers at 1 so reset never looks like a start bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_state_q    <= TX_IDLE;
         tx_baud_q     <= '0;
         tx_bit_q      <= 4'd0;
         tx_shift_q    <= '0;
         tx_par_q      <= 1'b0;
         txd_q         <= 1'b1;
         rx_state_q    <= RX_IDLE;
         rx_sync_q     <= 2'b11;
         rx_prev_q     <= 1'b1;
         rx_baud_q     <= '0;
         rx_bit_q      <= 4'd0;
         rx_shift_q    <= '0;
         rx_perr_q     <= 1'b0;
         rx_ferr_q     <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_perr_out_q <= 1'b0;
         rx_ferr_out_q <= 1'b0;
         rx_overrun_q  <= 1'b0;
      end else begin
         tx_state_q    <= tx_state_d;
         tx_baud_q     <= tx_baud_d;
         tx_bit_q      <= tx_bit_d;
         tx_shift_q    <= tx_shift_d;
         tx_par_q      <= tx_par_d;
         txd_q         <= txd_d;
         rx_state_q    <= rx_state_d;
         rx_sync_q     <= rx_sync_d;
         rx_prev_q     <= rx_prev_d;
         rx_baud_q     <= rx_baud_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         rx_perr_q     <= rx_perr_d;
         rx_ferr_q     <= rx_ferr_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         rx_perr_out_q <= rx_perr_out_d;
         rx_ferr_out_q <= rx_ferr_out_d;
         rx_overrun_q  <= rx_overrun_d;
      end
   end

   assign tx_ready      = tx_ready_s;
   assign txd           = txd_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_out_q;
   assign rx_frame_err  = rx_ferr_out_q;
   assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed self-checking bench for uart (8 data bits, even parity, 1 stop, 4 clk/bit).
// Flow-control expectations follow UART_FLOW_CTRL_EN when it is defined.
module tb_uart;

   localparam int BD = 4;
`ifdef UART_FLOW_CTRL_EN
   localparam logic FLOW = 1'b1;
`else
   localparam logic FLOW = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       rx_ready = 1'b0;
   logic       rxd_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       cts = 1'b1;
   logic       rxd;
   logic       tx_ready, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, txd, rts;
   logic [7:0] rx_data;

   assign rxd = loop_en ? txd : rxd_drv;

   uart #(.DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY(2), .BAUD_DIV(BD)) dut (
      .clk(clk), .resetn(resetn),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
      .txd(txd), .rxd(rxd), .rts(rts), .cts(cts)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int ovr_cnt  = 0;

   int         hs[3];
   logic [7:0] got_d[3];
   logic       got_p[3];
   logic       got_f[3];
   int         got_n;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      ovr_cnt += int'(rx_overrun);
   endtask

   task automatic wait_tx_ready(input int budget);
      int k = 0;
      while (!tx_ready && k < budget) begin
         tick();
         k++;
      end
      check("tx_ready_wait", tx_ready, 1);
   endtask

   // Drives start, data, parity, then sets the stop level and returns at the stop-bit start.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      rxd_drv = 1'b0;
      repeat (BD) tick();
      for (int i = 0; i < 8; i++) begin
         rxd_drv = d[i];
         repeat (BD) tick();
      end
      rxd_drv = par;
      repeat (BD) tick();
      rxd_drv = stp;
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("consume", rx_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] expb;
      logic [7:0]  words[3];
      int          low, v, seen;

      repeat (3) tick();
      check("rst_txd", txd, 1);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rts", rts, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_perr", rx_parity_err, 0);
      check("rst_ferr", rx_frame_err, 0);
      check("rst_ovr", rx_overrun, 0);
      resetn = 1'b1;
      tick();

      // TX 0xA5: start, LSB-first data, even parity 0, stop
      expb = {1'b1, 1'b0, 8'hA5, 1'b0};
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      low = 0;
      for (int n = 1; n <= 50; n++) begin
         if (n <= 44) check("tx_bit", txd, expb[(n-1)/4]);
         if (n == 45) check("tx_idle_after", txd, 1);
         low += int'(!tx_ready);
         tick();
      end
      check("tx_ready_low_cycles", low, 44);

      // Loopback, three words back-to-back
      words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
      loop_en  = 1'b1;
      rx_ready = 1'b1;
      got_n    = 0;
      fork
         begin
            tx_valid = 1'b1;
            for (int w = 0; w < 3; w++) begin
               int k = 0;
               tx_data = words[w];
               while (!tx_ready && k < 200) begin
                  @(negedge clk);
                  k++;
               end
               check("lb_tx_ready_wait", tx_ready, 1);
               hs[w] = cyc;
               @(negedge clk);
            end
            tx_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (rx_valid && rx_ready && got_n < 3) begin
                  got_d[got_n] = rx_data;
                  got_p[got_n] = rx_parity_err;
                  got_f[got_n] = rx_frame_err;
                  got_n++;
               end
            end
         end
      join
      loop_en  = 1'b0;
      rx_ready = 1'b0;
      check("lb_count", got_n, 3);
      for (int w = 0; w < 3; w++) begin
         check("lb_data", got_d[w], words[w]);
         check("lb_perr", got_p[w], 0);
         check("lb_ferr", got_f[w], 0);
      end
      check("lb_gap01", hs[1] - hs[0], 45);
      check("lb_gap12", hs[2] - hs[1], 45);

      // Parity error: 0x01 needs even-parity bit 1, send 0
      send_frame(8'h01, 1'b0, 1'b1);
      repeat (3) tick();
      check("rx_lat_early", rx_valid, 0);
      tick();
      check("rx_lat", rx_valid, 1);
      check("perr_data", rx_data, 8'h01);
      check("perr_flag", rx_parity_err, 1);
      check("perr_ferr", rx_frame_err, 0);
      repeat (4) tick();
      consume();

      // Frame error: correct parity, stop bit 0
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (4) tick();
      check("ferr_valid", rx_valid, 1);
      check("ferr_data", rx_data, 8'h55);
      check("ferr_flag", rx_frame_err, 1);
      check("ferr_perr", rx_parity_err, 0);
      rxd_drv = 1'b1;
      repeat (4) tick();
      consume();

      // One-cycle glitch must not produce a word
      rxd_drv = 1'b0;
      tick();
      rxd_drv = 1'b1;
      v = 0;
      repeat (60) begin
         tick();
         v += int'(rx_valid);
      end
      check("glitch_no_valid", v, 0);

      // Overrun: second word dropped while first is held
      ovr_cnt = 0;
      send_frame(8'h11, 1'b0, 1'b1);
      repeat (4) tick();
      check("ovr_first_valid", rx_valid, 1);
      check("ovr_first_data", rx_data, 8'h11);
      check("rts_held", rts, FLOW ? 1'b0 : 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      repeat (8) tick();
      check("ovr_pulses", ovr_cnt, 1);
      check("ovr_data_kept", rx_data, 8'h11);
      check("ovr_valid_kept", rx_valid, 1);
      send_frame(8'h33, 1'b0, 1'b1);
      repeat (3) tick();
      rx_ready = 1'b1;
      tick();
      check("swap_valid", rx_valid, 1);
      check("swap_data", rx_data, 8'h33);
      check("swap_no_ovr", rx_overrun, 0);
      check("swap_ovr_total", ovr_cnt, 1);
      rx_ready = 1'b0;
      tick();
      check("swap_held", rx_valid, 1);
      consume();
      check("rts_free", rts, 1);

      // CTS handling
      cts = 1'b0;
      repeat (3) tick();
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      seen = 0;
`ifdef UART_FLOW_CTRL_EN
      v = 0;
      repeat (10) begin
         tick();
         v += int'(!txd);
      end
      check("cts_block_txd", v, 0);
      check("cts_block_ready", tx_ready, 0);
      cts = 1'b1;
`endif
      for (int k = 0; k < 4; k++) begin
         tick();
         if (!txd && seen == 0) begin
            seen = 1;
            tx_valid = 1'b0;
         end
      end
      tx_valid = 1'b0;
      check("cts_start_bit", seen, 1);
      cts = 1'b1;
      wait_tx_ready(100);

      // Reset during TX data bit 3, with loopback armed
      loop_en  = 1'b1;
      rx_ready = 1'b1;
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      repeat (16) tick();
      resetn = 1'b0;
      #1;
      check("rst_mid_txd", txd, 1);
      check("rst_mid_rx_valid", rx_valid, 0);
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      check("rst_rel_tx_ready", tx_ready, 1);
      check("rst_rel_txd", txd, 1);
      v = 0;
      repeat (60) begin
         tick();
         v += int'(rx_valid);
      end
      check("rst_no_spurious", v, 0);
      loop_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
